product_bcd_converter: RTL

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble) for the unsigned

---
 rtl/product_bcd_converter.sv | 103 ++++++++++
 1 files changed

// File: rtl/product_bcd_converter.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter for the multiplier product.
// Optional leading-zero blanking enabled by defining LEADING_ZERO_BLANK_EN.
module product_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IN_W-1:0]      bin_sr;
  logic [4*DIGITS-1:0]  scratch;
  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  scratch_nxt;
  logic [IN_W-1:0]      bin_nxt;

  // Add-3 correction on every digit in parallel, then shift {scratch,bin} left by one.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    scratch_nxt = {adj[4*DIGITS-2:0], bin_sr[IN_W-1]};
    bin_nxt     = {bin_sr[IN_W-2:0], 1'b0};
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      scratch <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          bin_sr  <= bin_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // Output loads on the edge that enters DONE so it is valid alongside done.
            bcd_out <= scratch_nxt;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              hi_zero;

  // Digit k blanks when it and every higher digit are zero; the ones digit always shows.
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (scratch_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = hi_zero;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      blank <= '0;
    else if (state == SHIFT && cnt == LAST_CNT)
      blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule
